// File: rtl/pid_pwm_driver.sv
// PWM output stage behind the PID controller: clamps the signed PID result to an
// 8-bit duty, buffers one sample, and slews the applied duty at period boundaries.
module pid_pwm_driver #(
    parameter int unsigned PERIOD   = 255,
    parameter int unsigned SLEW_MAX = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic signed [15:0] ctrl_in,
    input  logic               ctrl_valid,
    output logic               ctrl_ready,
    output logic               pwm_out,
    output logic               period_start,
    output logic [7:0]         duty_cur,
    output logic               sat
);

    localparam logic [7:0] CNT_LAST = 8'(PERIOD - 1);
    localparam logic [8:0] SLEW_9   = 9'(SLEW_MAX);

    logic [7:0] r_cnt;
    logic       r_run;
    logic [7:0] r_pending;
    logic       r_pending_full;
    logic [7:0] r_target;
    logic [7:0] r_duty;
    logic       r_pwm;
    logic       r_period_start;
    logic       r_sat;

    logic       w_accept;
    logic       w_boundary;
    logic [7:0] w_clamped;
    logic       w_clamp_hit;
    logic [7:0] w_cnt_next;
    logic [7:0] w_target_next;
    logic [7:0] w_duty_next;
    logic [8:0] w_step;
    logic [8:0] w_duty_sum;

    assign ctrl_ready = !r_pending_full;
    assign w_accept   = ctrl_valid && !r_pending_full;
    // r_run is low on the first enabled edge, so that edge restarts the period at 0.
    assign w_boundary = enable && r_run && (r_cnt == CNT_LAST);

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_clamped   = ctrl_in[7:0];
        w_clamp_hit = 1'b0;
        if (ctrl_in[15]) begin
            w_clamped   = 8'd0;
            w_clamp_hit = 1'b1;
        end else if (|ctrl_in[14:8]) begin
            w_clamped   = 8'd255;
            w_clamp_hit = 1'b1;
        end
    end

    always_comb begin
        w_cnt_next = 8'd0;
        if (enable && r_run && (r_cnt != CNT_LAST)) begin
            w_cnt_next = r_cnt + 8'd1;
        end
    end

    always_comb begin
        w_target_next = r_target;
        if (w_boundary && r_pending_full) begin
            w_target_next = r_pending;
        end
    end

    // 9-bit step arithmetic: the step never overshoots the target, so duty cannot wrap.
    always_comb begin
        w_step      = 9'd0;
        w_duty_sum  = {1'b0, r_duty};
        w_duty_next = r_duty;
        if (w_boundary) begin
            if (w_target_next > r_duty) begin
                w_step = {1'b0, w_target_next} - {1'b0, r_duty};
                if (w_step > SLEW_9) begin
                    w_step = SLEW_9;
                end
                w_duty_sum = {1'b0, r_duty} + w_step;
            end else begin
                w_step = {1'b0, r_duty} - {1'b0, w_target_next};
                if (w_step > SLEW_9) begin
                    w_step = SLEW_9;
                end
                w_duty_sum = {1'b0, r_duty} - w_step;
            end
            w_duty_next = w_duty_sum[7:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending      <= 8'd0;
            r_pending_full <= 1'b0;
            r_sat          <= 1'b0;
        end else begin
            if (w_accept) begin
                r_pending      <= w_clamped;
                r_pending_full <= 1'b1;
                r_sat          <= w_clamp_hit;
            end else if (w_boundary) begin
                r_pending_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= 8'd0;
            r_run    <= 1'b0;
            r_target <= 8'd0;
            r_duty   <= 8'd0;
        end else begin
            r_cnt    <= w_cnt_next;
            r_run    <= enable;
            r_target <= w_target_next;
            r_duty   <= w_duty_next;
        end
    end

    // Pin outputs are computed from the next-state values so they line up with cnt/duty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm          <= 1'b0;
            r_period_start <= 1'b0;
        end else begin
            r_pwm          <= enable && (w_cnt_next < w_duty_next);
            r_period_start <= enable && (w_cnt_next == 8'd0);
        end
    end

    assign pwm_out      = r_pwm;
    assign period_start = r_period_start;
    assign duty_cur     = r_duty;
    assign sat          = r_sat;

endmodule
